// File: rtl/wb_capture.sv
// Writeback capture FIFO: records every enabled CPU register writeback with a sequence
// tag and presents the oldest one to a show-ahead valid/ready consumer.
module wb_capture #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int SW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [DW-1:0]          wd,
  input  logic                   cap_en,
  input  logic                   clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_data,
  output logic [SW-1:0]          out_seq,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overflow,
  output logic [SW-1:0]          drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] DROP_MAX = '1;

  logic [DW-1:0] mem_data [DEPTH];
  logic [SW-1:0] mem_seq  [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] seq_q, seq_d;
  logic [SW-1:0] drop_q, drop_d;
  logic          ovf_q, ovf_d;

  logic push, pop, full_w, wr_en;

  // Handshake: the head entry transfers on a rising edge where out_valid=1 and
  // out_ready=1; out_ready is ignored while out_valid=0, and there is no push-to-pop bypass.
  assign full_w    = (count_q == DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = we & cap_en;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    seq_d    = seq_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      seq_d    = '0;
      drop_d   = '0;
      ovf_d    = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push) begin
        // The tag advances for dropped entries too, so gaps in out_seq expose drops.
        seq_d = seq_q + SW'(1);
        if (full_w && !pop) begin
          ovf_d = 1'b1;
          if (drop_q != DROP_MAX) begin
            drop_d = drop_q + SW'(1);
          end
        end else begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
        end
      end
      case ({wr_en, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; the read port is gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr_q] <= wd;
      mem_seq[wr_ptr_q]  <= seq_q;
    end
  end

  assign out_data = out_valid ? mem_data[rd_ptr_q] : '0;
  assign out_seq  = out_valid ? mem_seq[rd_ptr_q]  : '0;
  assign count    = count_q;
  assign full     = full_w;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_wb_capture.sv
// Bench for wb_capture: directed scenarios plus randomized traffic, compared each
// cycle against a queue-based model of the capture FIFO.
module tb_wb_capture;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int SW    = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [DW-1:0] wd;
  logic          cap_en;
  logic          clr;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_seq;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;
  logic [SW-1:0] drop_cnt;

  wb_capture #(.DW(DW), .DEPTH(DEPTH), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .wd        (wd),
    .cap_en    (cap_en),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_seq   (out_seq),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  logic [SW+DW-1:0] exp_q[$];   // {seq, data}, head at index 0
  int m_seq;
  int m_drop;
  bit m_ovf;
  int n_chk;
  int n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_seq  = 0;
    m_drop = 0;
    m_ovf  = 0;
  endtask

  task automatic compare_outputs();
    logic [SW+DW-1:0] head;
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("count",     32'(count),     32'(exp_q.size()));
    chk("full",      32'(full),      32'(exp_q.size() == DEPTH));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("drop_cnt",  32'(drop_cnt),  32'(m_drop));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      chk("out_data", 32'(out_data), 32'(head[DW-1:0]));
      chk("out_seq",  32'(out_seq),  32'(head[SW+DW-1:DW]));
    end else begin
      chk("out_data_idle", 32'(out_data), 32'd0);
      chk("out_seq_idle",  32'(out_seq),  32'd0);
    end
  endtask

  // ---------------- driver ----------------
  // Called #1 after a rising edge: drives inputs, checks current outputs,
  // advances the model by one clock, then waits for that edge.
  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit en, input bit c, input bit r);
    bit do_pop;
    we = w; wd = d; cap_en = en; clr = c; out_ready = r;
    compare_outputs();
    if (c) begin
      model_reset();
    end else begin
      do_pop = (exp_q.size() != 0) && r;
      if (do_pop) void'(exp_q.pop_front());
      if (w && en) begin
        if (exp_q.size() == DEPTH) begin
          m_ovf = 1;
          if (m_drop < (1 << SW) - 1) m_drop++;
        end else begin
          exp_q.push_back({SW'(m_seq), d});
        end
        m_seq = (m_seq + 1) % (1 << SW);
      end
    end
    @(posedge clk);
    #1;
    we = 0; clr = 0; out_ready = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 1, 0, 0);
  endtask

  logic [DW-1:0] t1_vals [3];
  int rdy_pct;

  initial begin
    n_chk = 0; n_pass = 0;
    t1_vals[0] = 16'h1111; t1_vals[1] = 16'h2222; t1_vals[2] = 16'h3333;
    rst = 1'b0; we = 0; wd = '0; cap_en = 0; clr = 0; out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    compare_outputs();

    // 1: three captures, then drain in order
    for (int i = 0; i < 3; i++) cycle(1, t1_vals[i], 1, 0, 0);
    chk("t1_count", 32'(count), 32'd3);
    chk("t1_head", 32'(out_data), 32'h1111);
    for (int i = 0; i < 3; i++) begin
      chk("t1_pop_data", 32'(out_data), 32'(t1_vals[i]));
      chk("t1_pop_seq", 32'(out_seq), 32'(i));
      cycle(0, '0, 1, 0, 1);
    end
    chk("t1_empty", 32'(out_valid), 32'd0);

    // 2: overflow by two
    cycle(0, '0, 1, 1, 0);
    for (int i = 0; i < 10; i++) cycle(1, 16'h00A0 + 16'(i), 1, 0, 0);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 8; i++) begin
      chk("t2_data", 32'(out_data), 32'h00A0 + 32'(i));
      chk("t2_seq", 32'(out_seq), 32'(i));
      cycle(0, '0, 1, 0, 1);
    end
    cycle(1, 16'h5555, 1, 0, 0);
    chk("t2_next_seq", 32'(out_seq), 32'd10);
    cycle(0, '0, 1, 0, 1);

    // 3: push and pop together while full
    for (int i = 0; i < 8; i++) cycle(1, 16'h0C00 + 16'(i), 1, 0, 0);
    chk("t3_full", 32'(full), 32'd1);
    cycle(1, 16'hBEEF, 1, 0, 1);
    chk("t3_count", 32'(count), 32'd8);
    chk("t3_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("t3_last", 32'(out_data), 32'hBEEF);
      cycle(0, '0, 1, 0, 1);
    end

    // 4: capture disabled, then clr with held entries and overflow
    cycle(0, '0, 1, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 16'h7777, 0, 0, 0);
    chk("t4_count", 32'(count), 32'd0);
    cycle(1, 16'h4444, 1, 0, 0);
    chk("t4_seq0", 32'(out_seq), 32'd0);
    for (int i = 0; i < 9; i++) cycle(1, 16'h4400 + 16'(i), 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0, 1);
    chk("t4_held", 32'(count), 32'd5);
    chk("t4_ovf_set", 32'(overflow), 32'd1);
    cycle(1, 16'h9999, 1, 1, 1);
    chk("t4_clr_count", 32'(count), 32'd0);
    chk("t4_clr_ovf", 32'(overflow), 32'd0);
    chk("t4_clr_drop", 32'(drop_cnt), 32'd0);
    cycle(1, 16'h4545, 1, 0, 0);
    chk("t4_clr_seq", 32'(out_seq), 32'd0);

    // 5: async reset mid-stream with a push pending
    for (int i = 0; i < 3; i++) cycle(1, 16'h5A00 + 16'(i), 1, 0, 0);
    we = 1; wd = 16'hDEAD; cap_en = 1;
    #2;
    rst = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_count", 32'(count), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1; we = 0;
    @(posedge clk);
    #1;
    compare_outputs();
    for (int i = 0; i < 300; i++) cycle(1, 16'($urandom), 1, 0, 0);
    chk("t5_drop_sat", 32'(drop_cnt), 32'd255);
    cycle(1, 16'h1234, 1, 0, 0);
    chk("t5_drop_hold", 32'(drop_cnt), 32'd255);
    cycle(0, '0, 1, 1, 0);

    // 6: randomized traffic with varying consumer pressure
    rdy_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rdy_pct = (($urandom_range(0, 2)) * 40) + 10;
      cycle($urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 9) != 0,
            $urandom_range(0, 199) == 0, $urandom_range(0, 99) < rdy_pct);
    end
    compare_outputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
